muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Parametrised multicycle multiply/divide sequencer feeding the HI/LO registers of the multicycle CPU datapath. The control unit drives `mult_start` and `div_start`, holds its state until `done`, then writes HI/LO. The unit is generalised in operand width and adds unsigned mode (multu/divu), a divide-by-zero indication that feeds the divzero exception state, and defined start/abort rules.

## Interface
- `WIDTH`, 32, operand width in bits; must be ≥ 4; HI/LO are each WIDTH bits.
- `clk` input 1: system clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-high reset; clears all state.
- `mult_start` input 1: start a multiply; sampled only in IDLE.
- `div_start` input 1: start a divide; sampled only in IDLE.
- `unsigned_op` input 1: 1 = unsigned operands (multu/divu); 0 = two's-complement; sampled with start.
- `a` input WIDTH: multiplicand or dividend; sampled with start.
- `b` input WIDTH: multiplier or divisor; sampled with start.
- `hi` output WIDTH: product upper half, or remainder.
- `lo` output WIDTH: product lower half, or quotient.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle completion pulse.
- `div_zero` output 1: one-cycle pulse, coincident with `done`, when a divide had `b == 0`.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - `mult_start` → MULT.
  - `div_start` with `b != 0` → DIV.
  - `div_start` with `b == 0` → DONE with `div_zero` set.
  - When `mult_start` and `div_start` are both high, multiply wins.
- On start, the unit latches `a`, `b`, `unsigned_op` and the op type into internal registers.
- In signed mode, operand magnitudes are taken and the result signs are recorded.
- Iteration counter loads WIDTH-1.
- MULT: radix-2 shift-add on magnitudes, one bit per cycle, into a 2·WIDTH accumulator.
- DIV: restoring division on magnitudes, one quotient bit per cycle, with a (WIDTH+1)-bit partial remainder.
- MULT and DIV leave after the counter reaches 0, i.e. WIDTH cycles, → FIX.
- FIX applies the sign correction:
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ, so it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - FIX loads `hi`/`lo` → DONE.
- DONE: `done` = 1 for exactly this cycle → IDLE.
- Divide-by-zero path: `hi`/`lo` keep their previous values; no iteration occurs.
- Signed most-negative ÷ −1: `lo` = most-negative value (wraps), `hi` = 0, no flag.
- All arithmetic is modulo 2^WIDTH per output half; the product is exact over 2·WIDTH bits.
- Starts asserted outside IDLE are ignored. They are not queued.
- Input changes after the start cycle have no effect on the result.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0, state = IDLE, counter = 0.
- Reset asserted mid-operation aborts immediately (asynchronously); no `done` is produced.
- Start sampled at edge E0.
- `busy` = 1 from after E0 through the FIX cycle.
- `hi`/`lo` update and `done` = 1 in the cycle after edge E0+WIDTH+1. Total latency is WIDTH+2 edges from the start edge to the end of the `done` cycle.
- `busy` = 0 during the DONE cycle.
- A new start is accepted at the edge ending the DONE cycle only if the unit is in IDLE. Earliest accepted start is the edge after DONE.
- Divide-by-zero: `done` = `div_zero` = 1 in the cycle after E0; `busy` stays 0 throughout.
- `hi`/`lo` are stable at all times except the single update edge; they hold until the next successful completion.
- `done` and `div_zero` are registered outputs with no combinational input-to-output paths.

## Test plan
- WIDTH=32, signed mult `a`=0xFFFFFFFD (−3), `b`=7 → `done` in the 34th cycle after the start edge; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high 33 cycles.
- Unsigned mult `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. Same operands signed → `hi`=0, `lo`=1.
- Signed div `a`=0xFFFFFFF9 (−7), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Unsigned div 100/7 → `lo`=14, `hi`=2.
- Div with `b`=0 after a prior result `hi`=5, `lo`=9 → `done` and `div_zero` high one cycle after start, `busy` never high, `hi`=5, `lo`=9 unchanged.
- Signed 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0.
- Start a mult, pulse `reset` at cycle 10 → all outputs 0 immediately, no `done`. Restart 7×6 → `lo`=42 after the normal latency.
- With `mult_start` and `div_start` both high → multiply result.
- Starts pulsed while `busy` → ignored; the result matches the first operation only.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Start/operand bundle from the control unit and HI/LO result bundle back from the sequencer.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             mult_start;
  logic             div_start;
  logic             unsigned_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output mult_start, div_start, unsigned_op, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  mult_start, div_start, unsigned_op, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multicycle signed/unsigned multiply-divide into HI/LO; done WIDTH+2 edges after start, 1 edge for divide-by-zero.
// No backpressure: starts are only sampled in IDLE and are dropped (not queued) while busy or during DONE.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_div_zero;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_mult_go;
  logic               w_div_go;
  logic               w_dz_go;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_rem_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_busy;
  logic               w_done;

  assign w_a_neg = ~bus.unsigned_op & bus.a[WIDTH-1];
  assign w_b_neg = ~bus.unsigned_op & bus.b[WIDTH-1];
  assign w_mag_a = w_a_neg ? -bus.a : bus.a;
  assign w_mag_b = w_b_neg ? -bus.b : bus.b;

  // Multiply has priority over divide when both starts arrive together.
  assign w_mult_go = (r_state == S_IDLE) & bus.mult_start;
  assign w_div_go  = (r_state == S_IDLE) & ~bus.mult_start & bus.div_start & (bus.b != '0);
  assign w_dz_go   = (r_state == S_IDLE) & ~bus.mult_start & bus.div_start & (bus.b == '0);

  // Shift-add step: conditionally add multiplicand into the upper half, then shift right.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{r_acc[0]}} & r_mag_a};

  // Restoring step on the (WIDTH+1)-bit shifted remainder; the difference always fits WIDTH bits.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = w_rem_sh >= {1'b0, r_mag_b};
  assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_mag_b;

  assign w_prod    = r_neg_res ? -r_acc : r_acc;
  assign w_quo_fix = r_neg_res ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_rem ? -r_rem : r_rem;

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mult_go)     w_next = S_MULT;
        else if (w_div_go) w_next = S_DIV;
        else if (w_dz_go)  w_next = S_DONE;
      end
      S_MULT: begin
        w_busy = 1'b1;
        if (r_cnt == '0) w_next = S_FIX;
      end
      S_DIV: begin
        w_busy = 1'b1;
        if (r_cnt == '0) w_next = S_FIX;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_acc      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_div_zero <= w_dz_go;
      case (r_state)
        S_IDLE: begin
          if (w_mult_go) begin
            r_acc     <= {{WIDTH{1'b0}}, w_mag_b};
            r_mag_a   <= w_mag_a;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_is_div  <= 1'b0;
            r_cnt     <= CW'(WIDTH-1);
          end else if (w_div_go) begin
            r_quo     <= w_mag_a;
            r_rem     <= '0;
            r_mag_b   <= w_mag_b;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_is_div  <= 1'b1;
            r_cnt     <= CW'(WIDTH-1);
          end
        end
        S_MULT: begin
          r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_DIV: begin
          r_rem <= w_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.div_zero = r_div_zero;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           dz;
    int           lat;
    int           busy_n;
  } res_t;

  logic         clk;
  logic         reset;
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  muldiv_seq_if #(.WIDTH(W)) bus ();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; divide-by-zero leaves HI/LO alone.
  function automatic void model(input bit ms, input bit ds, input bit uns,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                inout logic [W-1:0] mh, inout logic [W-1:0] ml,
                                output bit dz, output int lat, output int bn);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    dz = 1'b0; lat = W + 2; bn = W + 1;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a};           ub = {32'b0, b};
    if (ms) begin
      if (uns) p = ua * ub;
      else     p = longint'(sa * sb);
      mh = p[2*W-1:W]; ml = p[W-1:0];
    end else if (ds) begin
      if (b == '0) begin
        dz = 1'b1; lat = 1; bn = 0;
      end else if (uns) begin
        ml = a / b; mh = a % b;
      end else begin
        q = sa / sb; r = sa % sb;
        ml = q[W-1:0]; mh = r[W-1:0];
      end
    end
  endfunction

  task automatic do_op(input bit ms, input bit ds, input bit uns,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit interfere, output res_t obs, output res_t exp);
    logic [W-1:0] eh, el;
    bit           edz;
    int           elat, ebn;
    eh = m_hi; el = m_lo;
    model(ms, ds, uns, a, b, eh, el, edz, elat, ebn);
    exp.hi = eh; exp.lo = el; exp.dz = edz; exp.lat = elat; exp.busy_n = ebn;
    m_hi = eh; m_lo = el;
    obs.hi = 'x; obs.lo = 'x; obs.dz = 1'b0; obs.lat = 0; obs.busy_n = 0;
    @(negedge clk);
    bus.mult_start = ms; bus.div_start = ds; bus.unsigned_op = uns; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    bus.mult_start = 1'b0; bus.div_start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.unsigned_op = 1'($urandom_range(0, 1));
    for (int k = 1; k <= W + 8; k++) begin
      @(negedge clk);
      if (interfere) begin
        bus.mult_start = 1'b0; bus.div_start = 1'b0;
        if (k == 3 || k == 17 || k == W + 1) begin
          bus.mult_start = 1'b1; bus.div_start = 1'b1;
          bus.a = $urandom; bus.b = $urandom;
        end
      end
      if (bus.busy) obs.busy_n++;
      if (bus.done) begin
        obs.lat = k; obs.dz = bus.div_zero; obs.hi = bus.hi; obs.lo = bus.lo;
        break;
      end
    end
    bus.mult_start = 1'b0; bus.div_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.hi !== '0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== '0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", bus.div_zero); end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult();
    res_t o, e;
    do_op(1'b1, 1'b0, 1'b0, 32'hFFFFFFFD, 32'd7, 1'b0, o, e);
    checks++; if (o.lat !== 34) begin failures++; $display("FAIL smul_latency got=%0d exp=34", o.lat); end
    checks++; if (o.busy_n !== 33) begin failures++; $display("FAIL smul_busy_cycles got=%0d exp=33", o.busy_n); end
    checks++; if (o.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL smul_hi got=%h exp=ffffffff", o.hi); end
    checks++; if (o.lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL smul_lo got=%h exp=ffffffeb", o.lo); end
    checks++; if (o.dz !== 1'b0) begin failures++; $display("FAIL smul_dz got=%b exp=0", o.dz); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", bus.done); end
    do_op(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, o, e);
    checks++; if (o.hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL umul_hi got=%h exp=fffffffe", o.hi); end
    checks++; if (o.lo !== 32'h00000001) begin failures++; $display("FAIL umul_lo got=%h exp=00000001", o.lo); end
    do_op(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, o, e);
    checks++; if (o.hi !== 32'h0) begin failures++; $display("FAIL smul_m1_hi got=%h exp=0", o.hi); end
    checks++; if (o.lo !== 32'h1) begin failures++; $display("FAIL smul_m1_lo got=%h exp=1", o.lo); end
  endtask

  task automatic test_div();
    res_t o, e;
    do_op(1'b0, 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 1'b0, o, e);
    checks++; if (o.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL sdiv_quo got=%h exp=fffffffd", o.lo); end
    checks++; if (o.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL sdiv_rem got=%h exp=ffffffff", o.hi); end
    checks++; if (o.lat !== 34) begin failures++; $display("FAIL sdiv_latency got=%0d exp=34", o.lat); end
    do_op(1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 1'b0, o, e);
    checks++; if (o.lo !== 32'd14) begin failures++; $display("FAIL udiv_quo got=%0d exp=14", o.lo); end
    checks++; if (o.hi !== 32'd2) begin failures++; $display("FAIL udiv_rem got=%0d exp=2", o.hi); end
  endtask

  task automatic test_div_zero();
    res_t o, e;
    do_op(1'b0, 1'b1, 1'b1, 32'd68, 32'd7, 1'b0, o, e);
    checks++; if (o.hi !== 32'd5 || o.lo !== 32'd9) begin
      failures++; $display("FAIL dz_setup got=%h/%h exp=5/9", o.hi, o.lo);
    end
    do_op(1'b0, 1'b1, 1'b0, 32'd1234, 32'd0, 1'b0, o, e);
    checks++; if (o.lat !== 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", o.lat); end
    checks++; if (o.dz !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", o.dz); end
    checks++; if (o.busy_n !== 0) begin failures++; $display("FAIL dz_busy got=%0d exp=0", o.busy_n); end
    checks++; if (o.hi !== 32'd5 || o.lo !== 32'd9) begin
      failures++; $display("FAIL dz_hold got=%h/%h exp=5/9", o.hi, o.lo);
    end
    @(negedge clk);
    checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL dz_pulse got=%b exp=0", bus.div_zero); end
  endtask

  task automatic test_most_neg();
    res_t o, e;
    do_op(1'b0, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0, o, e);
    checks++; if (o.lo !== 32'h80000000) begin failures++; $display("FAIL mneg_quo got=%h exp=80000000", o.lo); end
    checks++; if (o.hi !== 32'h0) begin failures++; $display("FAIL mneg_rem got=%h exp=0", o.hi); end
    checks++; if (o.dz !== 1'b0) begin failures++; $display("FAIL mneg_dz got=%b exp=0", o.dz); end
  endtask

  task automatic test_both_starts();
    res_t o, e;
    do_op(1'b1, 1'b1, 1'b0, 32'd6, 32'd3, 1'b0, o, e);
    checks++; if (o.lo !== 32'd18 || o.hi !== 32'd0) begin
      failures++; $display("FAIL both_starts got=%h/%h exp=0/18", o.hi, o.lo);
    end
  endtask

  task automatic test_ignore_busy();
    res_t o, e;
    bit   extra;
    do_op(1'b1, 1'b0, 1'b0, 32'h00012345, 32'hFFFF0003, 1'b1, o, e);
    checks++; if (o.hi !== e.hi || o.lo !== e.lo) begin
      failures++; $display("FAIL busy_ignore got=%h/%h exp=%h/%h", o.hi, o.lo, e.hi, e.lo);
    end
    checks++; if (o.lat !== 34) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=34", o.lat); end
    extra = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0) begin failures++; $display("FAIL busy_no_queue got=%b exp=0", extra); end
  endtask

  task automatic test_abort();
    res_t o, e;
    bit   seen;
    @(negedge clk);
    bus.mult_start = 1'b1; bus.unsigned_op = 1'b0; bus.a = 32'd123; bus.b = 32'd456;
    @(posedge clk);
    #1 bus.mult_start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", bus.busy); end
    reset = 1'b1;
    #1;
    checks++; if ({bus.hi, bus.lo} !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear got hi=%h lo=%h busy=%b done=%b dz=%b exp=all 0", bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", seen); end
    do_op(1'b1, 1'b0, 1'b0, 32'd7, 32'd6, 1'b0, o, e);
    checks++; if (o.lo !== 32'd42 || o.hi !== 32'd0) begin
      failures++; $display("FAIL abort_restart got=%h/%h exp=0/42", o.hi, o.lo);
    end
    checks++; if (o.lat !== 34) begin failures++; $display("FAIL abort_restart_latency got=%0d exp=34", o.lat); end
  endtask

  task automatic test_random();
    res_t         o, e;
    bit           ms, ds, uns;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      ms  = 1'($urandom_range(0, 1));
      ds  = ms ? 1'($urandom_range(0, 1)) : 1'b1;
      uns = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h80000000;
        default: ;
      endcase
      do_op(ms, ds, uns, a, b, 1'b0, o, e);
      checks++; if (o.hi !== e.hi || o.lo !== e.lo) begin
        failures++;
        $display("FAIL rand_result op=%0d%0d uns=%0d a=%h b=%h got=%h/%h exp=%h/%h", ms, ds, uns, a, b, o.hi, o.lo, e.hi, e.lo);
      end
      checks++; if (o.dz !== e.dz || o.lat !== e.lat || o.busy_n !== e.busy_n) begin
        failures++;
        $display("FAIL rand_timing a=%h b=%h got dz=%0d lat=%0d busy=%0d exp dz=%0d lat=%0d busy=%0d",
                 a, b, o.dz, o.lat, o.busy_n, e.dz, e.lat, e.busy_n);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.mult_start = 1'b0; bus.div_start = 1'b0; bus.unsigned_op = 1'b0;
    bus.a = '0; bus.b = '0;
    m_hi = '0; m_lo = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_most_neg();
    test_both_starts();
    test_ignore_busy();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
